// File: rtl/mem8_pkg.sv
// rtl/mem8_pkg.sv - shared types and constants for the mem_8 register bank arbiter
package mem8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SRST  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam int unsigned CMD_ADDR_DEF  = 1;
  localparam logic [7:0]  CMD_RST_DEF   = 8'h0F;
  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_SRST_BIT = 1;

endpackage

// File: rtl/mem8_regbank.sv
// rtl/mem8_regbank.sv - register bank, one write port, one registered read port, clear-by-address
module mem8_regbank
  import mem8_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear and normal writes never coincide: clearing only happens while the ports are stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (clr)     mem[clr_addr] <= '0;
      else if (we) mem[waddr]    <= wdata;
      if (re)      rdata         <= mem[raddr];
    end
  end

endmodule

// File: rtl/mem8_arb_ctrl.sv
// rtl/mem8_arb_ctrl.sv - host/local arbiter and soft-reset sequencer for the mem_8 bank
// Optional bank clear after soft reset: define MEM8_CLR_ON_RST_EN.
module mem8_arb_ctrl
  import mem8_pkg::*;
#(
  parameter int                ADDR_W   = 5,
  parameter int                DATA_W   = 8,
  parameter int                CMD_ADDR = CMD_ADDR_DEF,
  parameter logic [DATA_W-1:0] CMD_RST  = DATA_W'(CMD_RST_DEF),
  parameter int                RST_CYC  = 16,
  parameter int                MAX_WAIT = 8
) (
  input  logic              bus_clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] user_mem_8_addr,
  input  logic              user_w_mem_8_wren,
  input  logic [DATA_W-1:0] user_w_mem_8_data,
  output logic              user_w_mem_8_full,
  input  logic              user_r_mem_8_rden,
  output logic [DATA_W-1:0] user_r_mem_8_data,
  output logic              user_r_mem_8_empty,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic              loc_gnt,
  output logic [DATA_W-1:0] loc_rdata,
  output logic              loc_rvalid,
  output logic              soft_rst,
  output logic              busy
);

  localparam int CNT_W  = $clog2(RST_CYC + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t              state;
  logic                hold_q;
  logic [CNT_W-1:0]    srst_cnt;
  logic [ADDR_W-1:0]   clr_addr;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                rd_stat_q;
  logic [DATA_W-1:0]   stat_q;
  logic [DATA_W-1:0]   status_now;
  logic [DATA_W-1:0]   bank_rdata;

  logic                open_q, loc_stall, port_stall;
  logic                host_wr, host_rd, loc_wr, loc_rd;
  logic                wr_any, bank_we, cmd_hit, rd_en;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic [DATA_W-1:0]   wr_data;

  // hold_q keeps the host port closed until the first clock after hard reset.
  assign open_q     = (state == IDLE) && !hold_q;
  assign loc_stall  = open_q && loc_req && (wait_cnt == WAIT_W'(MAX_WAIT));
  assign port_stall = !open_q || loc_stall;

  assign user_w_mem_8_full  = port_stall;
  assign user_r_mem_8_empty = port_stall;
  assign loc_gnt = open_q && loc_req && (loc_stall || !(user_w_mem_8_wren || user_r_mem_8_rden));

  assign host_wr = user_w_mem_8_wren && !port_stall;
  assign host_rd = user_r_mem_8_rden && !port_stall;
  assign loc_wr  = loc_gnt && loc_we;
  assign loc_rd  = loc_gnt && !loc_we;

  assign wr_any  = host_wr || loc_wr;
  assign wr_addr = host_wr ? user_mem_8_addr : loc_addr;
  assign wr_data = host_wr ? user_w_mem_8_data : loc_wdata;
  assign bank_we = wr_any && (wr_addr != '0);
  assign cmd_hit = wr_any && (wr_addr == ADDR_W'(CMD_ADDR)) && (wr_data == CMD_RST);

  assign rd_en   = host_rd || loc_rd;
  assign rd_addr = host_rd ? user_mem_8_addr : loc_addr;

  always_comb begin
    status_now                = '0;
    status_now[STAT_BUSY_BIT] = busy;
    status_now[STAT_SRST_BIT] = soft_rst;
  end

  assign user_r_mem_8_data = rd_stat_q ? stat_q : bank_rdata;
  assign loc_rdata         = user_r_mem_8_data;

  mem8_regbank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank (
    .clk      (bus_clk),
    .rst      (rst),
    .we       (bank_we),
    .waddr    (wr_addr),
    .wdata    (wr_data),
    .clr      (state == CLEAR),
    .clr_addr (clr_addr),
    .re       (rd_en),
    .raddr    (rd_addr),
    .rdata    (bank_rdata)
  );

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_q     <= 1'b1;
      srst_cnt   <= '0;
      clr_addr   <= '0;
      wait_cnt   <= '0;
      soft_rst   <= 1'b0;
      busy       <= 1'b0;
      loc_rvalid <= 1'b0;
      rd_stat_q  <= 1'b0;
      stat_q     <= '0;
    end else begin
      hold_q     <= 1'b0;
      loc_rvalid <= loc_rd;
      if (rd_en) begin
        rd_stat_q <= (rd_addr == '0);
        stat_q    <= status_now;
      end
      case (state)
        IDLE: begin
          if (loc_gnt)                wait_cnt <= '0;
          else if (loc_req && open_q) wait_cnt <= wait_cnt + 1'b1;
          if (cmd_hit) begin
            state    <= SRST;
            srst_cnt <= CNT_W'(RST_CYC - 1);
            soft_rst <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SRST: begin
          if (srst_cnt == '0) begin
            soft_rst <= 1'b0;
`ifdef MEM8_CLR_ON_RST_EN
            state    <= CLEAR;
            clr_addr <= ADDR_W'(1);
`else
            state    <= IDLE;
            busy     <= 1'b0;
`endif
          end else begin
            srst_cnt <= srst_cnt - 1'b1;
          end
        end
        CLEAR: begin
          if (clr_addr == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem8_arb_ctrl.sv
// tb/tb_mem8_arb_ctrl.sv - self-checking bench for mem8_arb_ctrl (honours MEM8_CLR_ON_RST_EN)
module tb_mem8_arb_ctrl;

  localparam int DEPTH    = 32;
  localparam int RST_CYC  = 16;
  localparam int MAX_WAIT = 8;
`ifdef MEM8_CLR_ON_RST_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic       bus_clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] user_mem_8_addr = '0;
  logic       user_w_mem_8_wren = 1'b0;
  logic [7:0] user_w_mem_8_data = '0;
  logic       user_w_mem_8_full;
  logic       user_r_mem_8_rden = 1'b0;
  logic [7:0] user_r_mem_8_data;
  logic       user_r_mem_8_empty;
  logic       loc_req = 1'b0;
  logic       loc_we = 1'b0;
  logic [4:0] loc_addr = '0;
  logic [7:0] loc_wdata = '0;
  logic       loc_gnt;
  logic [7:0] loc_rdata;
  logic       loc_rvalid;
  logic       soft_rst;
  logic       busy;

  mem8_arb_ctrl dut (
    .bus_clk            (bus_clk),
    .rst                (rst),
    .user_mem_8_addr    (user_mem_8_addr),
    .user_w_mem_8_wren  (user_w_mem_8_wren),
    .user_w_mem_8_data  (user_w_mem_8_data),
    .user_w_mem_8_full  (user_w_mem_8_full),
    .user_r_mem_8_rden  (user_r_mem_8_rden),
    .user_r_mem_8_data  (user_r_mem_8_data),
    .user_r_mem_8_empty (user_r_mem_8_empty),
    .loc_req            (loc_req),
    .loc_we             (loc_we),
    .loc_addr           (loc_addr),
    .loc_wdata          (loc_wdata),
    .loc_gnt            (loc_gnt),
    .loc_rdata          (loc_rdata),
    .loc_rvalid         (loc_rvalid),
    .soft_rst           (soft_rst),
    .busy               (busy)
  );

  always #5 bus_clk = ~bus_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: bank contents plus "cycles remaining" counters for soft reset and clear.
  logic [7:0] mem_m [DEPTH];
  int  srst_left, clr_left, waitc;
  bit  exp_hrd, exp_lrd, dut_gnt;
  logic [7:0] exp_hdata, exp_ldata;

  typedef struct {
    bit         wr;
    bit         rd;
    logic [4:0] addr;
    logic [7:0] data;
    bit         chk;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    srst_left = 0;
    clr_left  = 0;
    waitc     = 0;
  endtask

  function automatic logic [7:0] mread(input int a);
    return (a == 0) ? 8'h00 : mem_m[a];
  endfunction

  task automatic mwrite(input int a, input logic [7:0] d);
    if (a != 0) mem_m[a] = d;
    if (a == 1 && d == 8'h0F) srst_left = RST_CYC;
  endtask

  task automatic idle_inputs();
    user_w_mem_8_wren = 1'b0;
    user_r_mem_8_rden = 1'b0;
    loc_req = 1'b0;
  endtask

  // Called at posedge+1 with inputs applied; checks comb outputs, clocks once, checks registered outputs.
  task automatic cycle();
    bit stalled, stall_loc, gnt, hw, hr;
    int ha, la;
    #1;
    stalled   = (srst_left > 0) || (clr_left > 0);
    stall_loc = !stalled && loc_req && (waitc == MAX_WAIT);
    gnt       = !stalled && loc_req && (stall_loc || !(user_w_mem_8_wren || user_r_mem_8_rden));
    chk("full", user_w_mem_8_full, stalled || stall_loc);
    chk("empty", user_r_mem_8_empty, stalled || stall_loc);
    chk("loc_gnt", loc_gnt, gnt);
    dut_gnt = loc_gnt;
    exp_hrd = 1'b0;
    exp_lrd = 1'b0;
    ha = int'(user_mem_8_addr);
    la = int'(loc_addr);
    if (stalled) begin
      if (srst_left > 0) begin
        srst_left--;
        if (CLR_EN && srst_left == 0) clr_left = DEPTH - 1;
      end else begin
        mem_m[DEPTH - clr_left] = 8'h00;
        clr_left--;
      end
    end else begin
      hw = user_w_mem_8_wren && !stall_loc;
      hr = user_r_mem_8_rden && !stall_loc;
      if (hr) begin exp_hrd = 1'b1; exp_hdata = mread(ha); end
      if (gnt && !loc_we) begin exp_lrd = 1'b1; exp_ldata = mread(la); end
      if (hw) mwrite(ha, user_w_mem_8_data);
      if (gnt && loc_we) mwrite(la, loc_wdata);
      if (gnt) waitc = 0;
      else if (loc_req) waitc++;
    end
    @(posedge bus_clk);
    #1;
    if (exp_hrd) chk("host_rdata", user_r_mem_8_data, exp_hdata);
    if (exp_lrd) chk("loc_rdata", loc_rdata, exp_ldata);
    chk("loc_rvalid", loc_rvalid, exp_lrd);
    chk("soft_rst", soft_rst, srst_left > 0);
    chk("busy", busy, (srst_left > 0) || (clr_left > 0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge bus_clk);
    #1;
    chk("rst_full", user_w_mem_8_full, 1);
    chk("rst_empty", user_r_mem_8_empty, 1);
    chk("rst_soft_rst", soft_rst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_loc_gnt", loc_gnt, 0);
    chk("rst_loc_rvalid", loc_rvalid, 0);
    chk("rst_rdata", user_r_mem_8_data, 0);
    rst = 1'b0;
    @(posedge bus_clk);
    #1;
    model_reset();
  endtask

  task automatic host_op(input bit wr, input bit rd, input logic [4:0] a, input logic [7:0] d);
    user_w_mem_8_wren = wr;
    user_r_mem_8_rden = rd;
    user_mem_8_addr   = a;
    user_w_mem_8_data = d;
    cycle();
    user_w_mem_8_wren = 1'b0;
    user_r_mem_8_rden = 1'b0;
  endtask

  initial begin
    int n, guard, n_srst;

    vecs[0] = '{1, 0, 5'd3,  8'h55, 0, 8'h00};
    vecs[1] = '{0, 1, 5'd3,  8'h00, 1, 8'h55};
    vecs[2] = '{1, 0, 5'd0,  8'h12, 0, 8'h00};
    vecs[3] = '{0, 1, 5'd0,  8'h00, 1, 8'h00};
    vecs[4] = '{1, 0, 5'd1,  8'h0E, 0, 8'h00};
    vecs[5] = '{0, 1, 5'd1,  8'h00, 1, 8'h0E};
    vecs[6] = '{1, 0, 5'd31, 8'hC3, 0, 8'h00};
    vecs[7] = '{1, 1, 5'd31, 8'h3C, 1, 8'hC3};
    vecs[8] = '{0, 1, 5'd31, 8'h00, 1, 8'h3C};
    vecs[9] = '{0, 1, 5'd3,  8'h00, 1, 8'h55};

    do_reset();

    for (int i = 0; i < 10; i++) begin
      host_op(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data);
      if (vecs[i].chk) chk($sformatf("vec%0d", i), user_r_mem_8_data, vecs[i].exp);
    end

    // Soft reset: preload, trigger, measure pulse and busy length, inspect retained contents.
    for (int a = 2; a < DEPTH; a++) host_op(1, 0, 5'(a), 8'hAA);
    host_op(1, 0, 5'd1, 8'h0F);
    n_srst = 0;
    guard  = 0;
    while (busy && guard < 200) begin
      if (soft_rst) n_srst++;
      cycle();
      guard++;
    end
    chk("srst_len", n_srst, RST_CYC);
    chk("busy_len", guard, CLR_EN ? RST_CYC + DEPTH - 1 : RST_CYC);
    host_op(0, 1, 5'd2, 8'h00);
    chk("after_srst_a2", user_r_mem_8_data, CLR_EN ? 8'h00 : 8'hAA);
    host_op(0, 1, 5'd1, 8'h00);
    chk("after_srst_a1", user_r_mem_8_data, CLR_EN ? 8'h00 : 8'h0F);

    // Local write with idle host is granted in the same cycle.
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = 5'd7; loc_wdata = 8'h33;
    cycle();
    chk("t5_gnt", dut_gnt, 1);
    loc_req = 1'b0;
    host_op(0, 1, 5'd7, 8'h00);
    chk("t5_read", user_r_mem_8_data, 8'h33);

    // Continuous host reads starve the local read until the wait limit forces a grant.
    host_op(1, 0, 5'd5, 8'h5A);
    user_r_mem_8_rden = 1'b1;
    user_mem_8_addr   = 5'd3;
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 5'd5;
    n = 0;
    dut_gnt = 1'b0;
    while (!dut_gnt && n < 20) begin
      cycle();
      n++;
    end
    chk("t4_gnt_cycle", n, MAX_WAIT + 1);
    chk("t4_rvalid", loc_rvalid, 1);
    chk("t4_rdata", loc_rdata, 8'h5A);
    loc_req = 1'b0;
    user_r_mem_8_rden = 1'b0;
    cycle();

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      user_w_mem_8_wren = ($urandom_range(0, 3) == 0);
      user_r_mem_8_rden = ($urandom_range(0, 2) == 0);
      user_mem_8_addr   = 5'($urandom_range(0, DEPTH - 1));
      user_w_mem_8_data = ($urandom_range(0, 40) == 0) ? 8'h0F : 8'($urandom);
      if (!loc_req && $urandom_range(0, 2) == 0) begin
        loc_req   = 1'b1;
        loc_we    = 1'($urandom_range(0, 1));
        loc_addr  = 5'($urandom_range(0, DEPTH - 1));
        loc_wdata = 8'($urandom);
      end
      cycle();
      if (dut_gnt) loc_req = 1'b0;
    end
    idle_inputs();
    guard = 0;
    while ((srst_left > 0 || clr_left > 0) && guard < 200) begin
      cycle();
      guard++;
    end

    // Hard reset in the middle of a soft-reset pulse.
    host_op(1, 0, 5'd2, 8'hAA);
    host_op(1, 0, 5'd1, 8'h0F);
    repeat (4) cycle();
    rst = 1'b1;
    #1;
    chk("t6_soft_rst", soft_rst, 0);
    chk("t6_busy", busy, 0);
    do_reset();
    for (int a = 0; a < DEPTH; a++) host_op(0, 1, 5'(a), 8'h00);
    host_op(0, 1, 5'd2, 8'h00);
    chk("t6_a2_zero", user_r_mem_8_data, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
